// File: rtl/cla_sub_serial_if.sv
// Handshake and operand bus for the nibble-serial lookahead subtractor.
// The controller side drives start/operands; the subtractor side returns status and result.
interface cla_sub_serial_if #(
    parameter int N_NIBBLES = 4
);
    localparam int W = 4 * N_NIBBLES;

    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bIn;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bOut;
    logic         zero;

    modport master (
        output start, x, y, bIn,
        input  busy, done, d, bOut, zero
    );

    modport slave (
        input  start, x, y, bIn,
        output busy, done, d, bOut, zero
    );
endinterface

// File: rtl/cla_sub_serial.sv
// Nibble-serial subtractor: d = x - y - bIn computed one 4-bit lookahead slice per clock,
// LSB nibble first, with the borrow registered between slices.
module cla_sub_serial #(
    parameter int N_NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    cla_sub_serial_if.slave  bus
);
    localparam int W     = 4 * N_NIBBLES;
    localparam int CNT_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     xr;
    logic [W-1:0]     yr;
    logic [W-1:0]     dReg;
    logic             borrow;
    logic             bOutReg;
    logic             zeroReg;

    logic [3:0]       xNib;
    logic [3:0]       yNib;
    logic [3:0]       sliceSum;
    logic             sliceCarry;
    logic [W-1:0]     dMerged;

    // 4-bit carry-lookahead add: every carry is a flat sum of generate/propagate
    // products, so no carry depends on the previous one.
    function automatic logic [4:0] claAdd4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    // Subtraction as x + ~y + ~borrow; a missing carry-out means a borrow.
    always_comb begin
        xNib                    = xr[4*int'(cnt) +: 4];
        yNib                    = yr[4*int'(cnt) +: 4];
        {sliceCarry, sliceSum}  = claAdd4(xNib, ~yNib, ~borrow);
        dMerged                 = dReg;
        dMerged[4*int'(cnt) +: 4] = sliceSum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dReg    <= '0;
            borrow  <= 1'b0;
            bOutReg <= 1'b0;
            zeroReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        xr     <= bus.x;
                        yr     <= bus.y;
                        borrow <= bus.bIn;
                        cnt    <= '0;
                        dReg   <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    dReg   <= dMerged;
                    borrow <= ~sliceCarry;
                    if (cnt == LAST_CNT) begin
                        // zero must see the final nibble, so it is taken from the merged word
                        bOutReg <= ~sliceCarry;
                        zeroReg <= (dMerged == '0);
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.d    = dReg;
    assign bus.bOut = bOutReg;
    assign bus.zero = zeroReg;
endmodule

// File: tb/tb_cla_sub_serial.sv
// Bench for the nibble-serial subtractor: directed corner cases plus randomized operands
// compared against an integer-arithmetic reference.
module tb_cla_sub_serial;
    localparam int N   = 4;
    localparam int LAT = N + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    cla_sub_serial_if #(.N_NIBBLES(N)) bus ();

    cla_sub_serial #(.N_NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer subtraction, wrapped to 16 bits; borrow when it went negative.
    function automatic logic [17:0] refSub(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int          diff;
        logic [15:0] dd;
        diff = int'(a) - int'(b) - int'(bi);
        dd   = diff[15:0];
        return {(diff < 0), (dd == 16'h0000), dd};
    endfunction

    // Drives one start pulse from the current negedge and waits for done.
    // lat = number of negedges after the start edge at which done was seen, -1 on timeout.
    task automatic runOp(input logic [15:0] xi, input logic [15:0] yi, input logic bi, output int lat);
        bus.x     = xi;
        bus.y     = yi;
        bus.bIn   = bi;
        bus.start = 1'b1;
        lat       = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", bus.done); end
        vectors++; if (bus.d !== 16'h0000) begin miscompares++; $display("FAIL reset_d got=%h want=0000", bus.d); end
        vectors++; if (bus.bOut !== 1'b0) begin miscompares++; $display("FAIL reset_bOut got=%b want=0", bus.bOut); end
        vectors++; if (bus.zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got=%b want=0", bus.zero); end
    endtask

    task automatic test_directed();
        logic [15:0] tx [5] = '{16'h000A, 16'h0000, 16'h1234, 16'h1234, 16'h1000};
        logic [15:0] ty [5] = '{16'h0001, 16'h0001, 16'h1234, 16'h1234, 16'h0001};
        logic        tb [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] ed [5] = '{16'h0009, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0FFE};
        logic        eb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ez [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          lat;
        for (int i = 0; i < 5; i++) begin
            runOp(tx[i], ty[i], tb[i], lat);
            vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, LAT); end
            vectors++; if (bus.d !== ed[i]) begin miscompares++; $display("FAIL dir%0d_d got=%h want=%h", i, bus.d, ed[i]); end
            vectors++; if (bus.bOut !== eb[i]) begin miscompares++; $display("FAIL dir%0d_bOut got=%b want=%b", i, bus.bOut, eb[i]); end
            vectors++; if (bus.zero !== ez[i]) begin miscompares++; $display("FAIL dir%0d_zero got=%b want=%b", i, bus.zero, ez[i]); end
            // One cycle later: done dropped, back in IDLE, result held.
            bus.x = 16'hDEAD; bus.y = 16'hBEEF;
            @(negedge clk);
            vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL dir%0d_after_done done=%b busy=%b want 0/0", i, bus.done, bus.busy); end
            vectors++; if (bus.d !== ed[i]) begin miscompares++; $display("FAIL dir%0d_hold_d got=%h want=%h", i, bus.d, ed[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] xi;
        logic [15:0] yi;
        logic        bi;
        logic [17:0] exp;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            xi = 16'($urandom);
            yi = (i % 6 == 0) ? xi : 16'($urandom);
            bi = 1'($urandom);
            exp = refSub(xi, yi, bi);
            runOp(xi, yi, bi, lat);
            vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, LAT); end
            vectors++; if (bus.d !== exp[15:0]) begin miscompares++; $display("FAIL rnd%0d_d x=%h y=%h b=%b got=%h want=%h", i, xi, yi, bi, bus.d, exp[15:0]); end
            vectors++; if (bus.bOut !== exp[17]) begin miscompares++; $display("FAIL rnd%0d_bOut got=%b want=%b", i, bus.bOut, exp[17]); end
            vectors++; if (bus.zero !== exp[16]) begin miscompares++; $display("FAIL rnd%0d_zero got=%b want=%b", i, bus.zero, exp[16]); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_ignore();
        int          pulses = 0;
        logic [15:0] dAtDone = 16'h0000;
        int          firstDone = -1;
        bus.x = 16'h00FF; bus.y = 16'h0001; bus.bIn = 1'b0; bus.start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 2) begin
                bus.start = 1'b1; bus.x = 16'hFFFF; bus.y = 16'hFFFF; bus.bIn = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                pulses++;
                if (firstDone < 0) begin firstDone = n; dAtDone = bus.d; end
            end
        end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL busy_start_pulses got=%0d want=1", pulses); end
        vectors++; if (firstDone !== LAT) begin miscompares++; $display("FAIL busy_start_latency got=%0d want=%0d", firstDone, LAT); end
        vectors++; if (dAtDone !== 16'h00FE) begin miscompares++; $display("FAIL busy_start_d got=%h want=00fe", dAtDone); end
    endtask

    task automatic test_mid_reset();
        int lat;
        int pulses = 0;
        bus.x = 16'h1234; bus.y = 16'h0001; bus.bIn = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        vectors++; if (bus.d !== 16'h0000) begin miscompares++; $display("FAIL midrst_d got=%h want=0000", bus.d); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got=%b want=0", bus.done); end
        runOp(16'h0005, 16'h0003, 1'b0, lat);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL midrst_restart_latency got=%0d want=%0d", lat, LAT); end
        vectors++; if (bus.d !== 16'h0002) begin miscompares++; $display("FAIL midrst_restart_d got=%h want=0002", bus.d); end
        // Confirm the aborted operation never produces a late done.
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midrst_stray_done got=%0d want=0", pulses); end
    endtask

    task automatic test_reset_start_same_edge();
        bus.x = 16'h0042; bus.y = 16'h0001; bus.bIn = 1'b0;
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_start_busy got=%b want=0", bus.busy); end
        @(negedge clk);
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_start_idle busy=%b done=%b want 0/0", bus.busy, bus.done); end
        vectors++; if (bus.d !== 16'h0000) begin miscompares++; $display("FAIL rst_start_d got=%h want=0000", bus.d); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        bus.bIn   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back_ignore();
        test_mid_reset();
        test_reset_start_same_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cla_sub_serial.md
# cla_sub_serial

Nibble-serial subtractor, the inverse companion to the 4-bit carry-lookahead adder. It computes d = x − y − bIn over a parameterised width, one 4-bit lookahead slice per clock, with a registered borrow chained between slices. A start/busy/done handshake lets an ALU controller run multi-cycle subtractions on a single 4-bit lookahead slice instead of a full-width ripple chain.

## Interface
- N_NIBBLES, default 4: operand width in nibbles; W = 4·N_NIBBLES (default 16); legal range 1..16.
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset; sampled on rising clk only.
- start  in  1  request; accepted only when state is IDLE.
- x  in  W  minuend, unsigned; sampled on the accepting edge only.
- y  in  W  subtrahend, unsigned; sampled on the accepting edge only.
- bIn  in  1  borrow-in; sampled on the accepting edge only.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; d/bOut/zero valid.
- d  out  W  difference, modulo 2^W.
- bOut  out  1  borrow-out; 1 iff x < y + bIn (unsigned).
- zero  out  1  1 iff d == 0.

## Operation
- States: IDLE, CALC, DONE. Nibble counter cnt, width ceil(log2(N_NIBBLES)) (min 1). Registers: xr, yr, d, borrow.
- IDLE: start=1 → latch xr=x, yr=y, borrow=bIn, cnt=0, clear d to 0, go CALC. start=0 → stay.
- CALC, each edge: slice k=cnt computes xr[4k+3:4k] + ~yr[4k+3:4k] + ~borrow through a 4-bit generate/propagate lookahead (g=a&b, p=a^b, group carry from g/p terms, no ripple). Write sum into d[4k+3:4k]; borrow ← ~carry-out. cnt=N_NIBBLES−1 → go DONE, else cnt+1.
- DONE: done=1 for exactly this cycle; next edge → IDLE.
- bOut = borrow register after last slice; zero = (d == 0), registered on the CALC→DONE transition.
- d, bOut, zero hold their values in IDLE until the next accepted start. During CALC, d holds partial results and is not valid.
- start while busy=1: ignored, no queuing, operands not resampled.
- Operand changes after the accepting edge have no effect.
- Reset (any state, including mid-CALC): state=IDLE, cnt=0, d=0, borrow=0, bOut=0, zero=0, done=0, busy=0. The in-flight operation is discarded and done is not raised.
- Reset and start high on the same edge: reset wins.

## Timing
- Edge E0 samples start=1 in IDLE. Edges E1..E_N (N=N_NIBBLES) each compute one nibble, LSB nibble first.
- done=1 during the cycle after E_N, so the bench sees it at edge E_{N+1}. Default latency: start-edge to done-sample is 5 edges.
- busy rises after E0 and falls after E_{N+1}.
- Earliest next accepted start is edge E_{N+1}+1 (state back in IDLE). Throughput is one operation per N+2 cycles.
- N_NIBBLES=1: done is sampled at E2.
- Reset values: busy=0, done=0, d=0, bOut=0, zero=0.

## Test plan
- x=0x000A, y=0x0001, bIn=0, start pulse → done exactly 5 edges after start; d=0x0009, bOut=0, zero=0; d held after done drops.
- x=0x0000, y=0x0001, bIn=0 → d=0xFFFF, bOut=1, zero=0 (wrap-around, borrow through all 4 nibbles).
- x=0x1234, y=0x1234, bIn=0 → d=0x0000, zero=1, bOut=0. Then same x/y with bIn=1 → d=0xFFFF, bOut=1, zero=0.
- x=0x1000, y=0x0001, bIn=1 → d=0x0FFE, bOut=0 (borrow crosses nibbles 0→3).
- Start x=0x00FF, y=0x0001. At E2 assert start with x=0xFFFF, y=0xFFFF → ignored; result d=0x00FE, single done pulse.
- Start, assert rst at E2 for one cycle → busy=0, d=0, no done pulse. A new start at the next edge with x=5, y=3 → d=0x0002 with normal 5-edge latency. Also verify rst and start on the same edge leaves state IDLE.
